in_flight_return_buffer: RTL

//  Return side of the colored in-flight accounting. Accepts tagged responses (one per cycle) and stores them in
//  per-color FIFOs that share one RAM. Consumers drain by color; each drained word emits pop/pop_tag to the tracker.

---
 rtl/in_flight_return_buffer_pkg.sv | 20 ++
 rtl/in_flight_return_ram.sv | 33 +++
 rtl/in_flight_return_buffer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/in_flight_return_buffer_pkg.sv
// Shared constants for the colored in-flight tracker and its return buffer, so tags agree on both
// ends.
package in_flight_return_buffer_pkg;

  // Ceiling log2 for elaboration-time sizing; v is expected to be a power of two >= 2.
  function automatic int unsigned log2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned IFRB_COLORS = 4;
  localparam int unsigned IFRB_DEPTH  = 32;
  localparam int unsigned IFRB_WIDTH  = 64;
  localparam int unsigned IFRB_TAG_W  = log2(IFRB_COLORS);

endpackage

// File: rtl/in_flight_return_ram.sv
// Simple dual-port RAM backing all per-color FIFOs: synchronous write, registered read.
module in_flight_return_ram #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned WIDTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  localparam int unsigned Entries = 1 << ADDR_W;

  logic [WIDTH-1:0] mem [Entries];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the read register is reset; array contents are left undefined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/in_flight_return_buffer.sv
// Per-color return FIFOs sharing one RAM; each drained word retires its color to the tracker.
// Optional sticky error flag enabled by defining IFRB_ERR_CHECK_EN.
module in_flight_return_buffer
  import in_flight_return_buffer_pkg::*;
#(
  parameter int unsigned COLORS = IFRB_COLORS,
  parameter int unsigned DEPTH  = IFRB_DEPTH,
  parameter int unsigned WIDTH  = IFRB_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [log2(COLORS)-1:0]   in_tag,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      rd_en,
  input  logic [log2(COLORS)-1:0]   rd_tag,
  output logic                      rd_valid,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      pop,
  output logic [log2(COLORS)-1:0]   pop_tag,
  output logic [COLORS-1:0]         nonempty,
  output logic                      err
);

  localparam int unsigned TAG_W  = log2(COLORS);
  localparam int unsigned PTR_W  = log2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned ADDR_W = TAG_W + PTR_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q [COLORS];
  logic [PTR_W-1:0] wr_ptr_d [COLORS];
  logic [PTR_W-1:0] rd_ptr_q [COLORS];
  logic [PTR_W-1:0] rd_ptr_d [COLORS];
  logic [CNT_W-1:0] count_q  [COLORS];
  logic [CNT_W-1:0] count_d  [COLORS];

  logic              wr_acc, rd_acc;
  logic [COLORS-1:0] wr_sel, rd_sel;
  logic              rd_valid_q;
  logic [TAG_W-1:0]  pop_tag_q;

  // Both decisions use start-of-cycle counts: no bypass between a same-color write and read.
  assign wr_acc = in_valid && (count_q[in_tag] != FULL_CNT);
  assign rd_acc = rd_en && (count_q[rd_tag] != '0);
  assign wr_sel = wr_acc ? (COLORS'(1) << in_tag) : '0;
  assign rd_sel = rd_acc ? (COLORS'(1) << rd_tag) : '0;

  always_comb begin
    for (int c = 0; c < COLORS; c++) begin
      wr_ptr_d[c] = wr_ptr_q[c];
      rd_ptr_d[c] = rd_ptr_q[c];
      count_d[c]  = count_q[c];
      if (wr_sel[c]) wr_ptr_d[c] = wr_ptr_q[c] + PTR_W'(1);
      if (rd_sel[c]) rd_ptr_d[c] = rd_ptr_q[c] + PTR_W'(1);
      unique case ({wr_sel[c], rd_sel[c]})
        2'b10:   count_d[c] = count_q[c] + CNT_W'(1);
        2'b01:   count_d[c] = count_q[c] - CNT_W'(1);
        default: count_d[c] = count_q[c];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < COLORS; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        count_q[c]  <= '0;
      end
      rd_valid_q <= 1'b0;
      pop_tag_q  <= '0;
    end else begin
      for (int c = 0; c < COLORS; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        count_q[c]  <= count_d[c];
      end
      rd_valid_q <= rd_acc;
      if (rd_acc) pop_tag_q <= rd_tag;
    end
  end

  in_flight_return_ram #(
    .ADDR_W (ADDR_W),
    .WIDTH  (WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr ({in_tag, wr_ptr_q[in_tag]}),
    .wdata (in_data),
    .re    (rd_acc),
    .raddr ({rd_tag, rd_ptr_q[rd_tag]}),
    .rdata (rd_data)
  );

  always_comb begin
    nonempty = '0;
    for (int c = 0; c < COLORS; c++) nonempty[c] = (count_q[c] != '0);
  end

  assign rd_valid = rd_valid_q;
  assign pop      = rd_valid_q;
  assign pop_tag  = pop_tag_q;

`ifdef IFRB_ERR_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((in_valid && !wr_acc) || (rd_en && !rd_acc)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
